// File: rtl/move_scheduler.sv
// move_scheduler
//   Sequences per-mover 1-pixel moves through a shared wall/collision
//   checker. A tick snapshots the request and direction vectors; each
//   pending mover is then queried once (ISSUE), and the answer is turned
//   into a single-cycle step pulse (COMMIT). DONE closes the round and
//   advances the rotating start pointer so no mover is always served last.
//
// Optional feature macro: MOVE_SCHED_PAC_FIRST_EN
//   defined   - mover 0 (Pac-Man), if pending, is always queried first;
//               the ghosts follow in rotating order from ptr.
//   undefined - pure round-robin starting at ptr.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   tick         one-cycle round start pulse
//   req[3:0]     move requests (bit 0 Pac-Man, bits 1-3 ghosts)
//   dir_in[7:0]  2-bit direction per mover (00 up, 01 down, 10 left, 11 right)
//   chk_valid    checker query valid
//   chk_id[1:0]  mover being queried
//   chk_dir[1:0] direction being queried
//   chk_ready    checker response strobe
//   chk_free     checker result, valid with chk_ready (1 = open)
//   step[3:0]    one-hot move grant pulse
//   step_dir     direction accompanying step
//   busy         round in progress
//   round_done   one-cycle end-of-round pulse
//   overrun      sticky: tick seen while not idle
//   timeout_err  sticky: a query was abandoned after TIMEOUT wait cycles

module move_scheduler #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] req,
  input  logic [7:0] dir_in,
  output logic       chk_valid,
  output logic [1:0] chk_id,
  output logic [1:0] chk_dir,
  input  logic       chk_ready,
  input  logic       chk_free,
  output logic [3:0] step,
  output logic [1:0] step_dir,
  output logic       busy,
  output logic       round_done,
  output logic       overrun,
  output logic       timeout_err
);

  // The wait counter only needs to hold 0..TIMEOUT-1; reaching TIMEOUT-1
  // with no response is the abandon condition.
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COMMIT,
    DONE
  } state_t;

  state_t        state_reg;
  logic [1:0]    ptr_reg;
  logic [3:0]    pending_reg;
  logic [7:0]    dir_reg;
  logic [WW-1:0] wait_reg;

  logic          chk_valid_reg;
  logic [1:0]    chk_id_reg;
  logic [1:0]    chk_dir_reg;
  logic [3:0]    step_reg;
  logic [1:0]    step_dir_reg;
  logic          busy_reg;
  logic          round_done_reg;
  logic          overrun_reg;
  logic          timeout_err_reg;

  // ---------------------------------------------------------------------
  // Next-query selection. Outputs are registered, so the query for the
  // upcoming ISSUE cycle is chosen on the way into it: from the live
  // req/dir_in when a tick is accepted, otherwise from the latched copies.
  // ---------------------------------------------------------------------
  logic [3:0] src_pending;
  logic [7:0] src_dir;
  logic [1:0] rot_idx [4];
  logic [3:0] rot_hit;
  logic       sel_valid_next;
  logic [1:0] sel_id_next;
  logic [1:0] sel_dir_next;

  assign src_pending = (state_reg == IDLE) ? req    : pending_reg;
  assign src_dir     = (state_reg == IDLE) ? dir_in : dir_reg;

  // rot_idx[k] is the mover visited k-th when scanning upward from ptr.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_idx[gi] = ptr_reg + 2'(gi);
      assign rot_hit[gi] = src_pending[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    sel_valid_next = 1'b0;
    sel_id_next    = 2'd0;
    // Scan from the far end so the nearest pending mover wins.
    for (int k = 3; k >= 0; k--) begin
      if (rot_hit[k]) begin
        sel_valid_next = 1'b1;
        sel_id_next    = rot_idx[k];
      end
    end
`ifdef MOVE_SCHED_PAC_FIRST_EN
    // Pac-Man jumps the queue; once served its pending bit is clear and
    // the rotating scan above handles the ghosts unchanged.
    if (src_pending[0]) begin
      sel_id_next = 2'd0;
    end
`endif
    sel_dir_next = src_dir[2*sel_id_next +: 2];
  end

  // ---------------------------------------------------------------------
  // Round FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      ptr_reg         <= 2'd0;
      pending_reg     <= 4'd0;
      dir_reg         <= 8'd0;
      wait_reg        <= '0;
      chk_valid_reg   <= 1'b0;
      chk_id_reg      <= 2'd0;
      chk_dir_reg     <= 2'd0;
      step_reg        <= 4'd0;
      step_dir_reg    <= 2'd0;
      busy_reg        <= 1'b0;
      round_done_reg  <= 1'b0;
      overrun_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      step_reg       <= 4'd0;
      step_dir_reg   <= 2'd0;
      round_done_reg <= 1'b0;

      if (tick && (state_reg != IDLE)) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (tick) begin
            pending_reg   <= req;
            dir_reg       <= dir_in;
            chk_valid_reg <= sel_valid_next;
            chk_id_reg    <= sel_id_next;
            chk_dir_reg   <= sel_dir_next;
            wait_reg      <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= ISSUE;
          end
        end

        ISSUE: begin
          if (pending_reg == 4'd0) begin
            round_done_reg <= 1'b1;
            state_reg      <= DONE;
          end else if (chk_ready) begin
            pending_reg[chk_id_reg] <= 1'b0;
            chk_valid_reg           <= 1'b0;
            if (chk_free) begin
              step_reg     <= 4'b0001 << chk_id_reg;
              step_dir_reg <= chk_dir_reg;
            end
            state_reg <= COMMIT;
          end else if (wait_reg == WAIT_LAST) begin
            // Checker never answered: treat as a wall.
            pending_reg[chk_id_reg] <= 1'b0;
            chk_valid_reg           <= 1'b0;
            timeout_err_reg         <= 1'b1;
            state_reg               <= COMMIT;
          end else begin
            wait_reg <= wait_reg + 1'b1;
          end
        end

        COMMIT: begin
          // step is visible this cycle; line up the next query (or none,
          // which sends ISSUE straight to DONE).
          chk_valid_reg <= sel_valid_next;
          chk_id_reg    <= sel_id_next;
          chk_dir_reg   <= sel_dir_next;
          wait_reg      <= '0;
          state_reg     <= ISSUE;
        end

        DONE: begin
          ptr_reg   <= ptr_reg + 2'd1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign chk_valid   = chk_valid_reg;
  assign chk_id      = chk_id_reg;
  assign chk_dir     = chk_dir_reg;
  assign step        = step_reg;
  assign step_dir    = step_dir_reg;
  assign busy        = busy_reg;
  assign round_done  = round_done_reg;
  assign overrun     = overrun_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler
//   Randomized self-checking bench for move_scheduler. The reference model
//   keeps only the rotating pointer and sticky flags; each round's query
//   order is derived from the request vector, and a bench-side checker
//   responder answers queries after a chosen delay (or never, to force a
//   timeout). Build with +define+MOVE_SCHED_PAC_FIRST_EN to check the
//   Pac-Man-first ordering.

module tb_move_scheduler;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] req = 4'd0;
  logic [7:0] dir_in = 8'd0;
  logic       chk_ready = 1'b0;
  logic       chk_free = 1'b0;
  logic       chk_valid;
  logic [1:0] chk_id;
  logic [1:0] chk_dir;
  logic [3:0] step;
  logic [1:0] step_dir;
  logic       busy;
  logic       round_done;
  logic       overrun;
  logic       timeout_err;

  move_scheduler #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .req         (req),
    .dir_in      (dir_in),
    .chk_valid   (chk_valid),
    .chk_id      (chk_id),
    .chk_dir     (chk_dir),
    .chk_ready   (chk_ready),
    .chk_free    (chk_free),
    .step        (step),
    .step_dir    (step_dir),
    .busy        (busy),
    .round_done  (round_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int round_no = 0;

  // Reference state
  int ptr_m = 0;
  bit ovr_m = 1'b0;
  bit tmo_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (round %0d)", tag, got, exp, round_no);
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full round: r/d are the request and direction snapshot, fr the
  // checker's free answer per mover, dl the response delay per mover
  // (>= TO means never answer), inject pulses a stray tick mid-round.
  task automatic run_round(input logic [3:0] r, input logic [7:0] d,
                           input logic [3:0] fr, input int dl [4],
                           input bit inject);
    int         ord[$];
    int         m;
    int         cnt;
    bit         answered;
    logic [3:0] exp_step;
    string      ord_s;

    ord_s = "";
`ifdef MOVE_SCHED_PAC_FIRST_EN
    if (r[0]) ord.push_back(0);
    for (int k = 0; k < 4; k++) begin
      m = (ptr_m + k) % 4;
      if (r[m] && m != 0) ord.push_back(m);
    end
`else
    for (int k = 0; k < 4; k++) begin
      m = (ptr_m + k) % 4;
      if (r[m]) ord.push_back(m);
    end
`endif

    tick   = 1'b1;
    req    = r;
    dir_in = d;
    tick_cycle();
    tick   = 1'b0;
    // Scramble the live inputs; the round must use the snapshot.
    req    = 4'($urandom);
    dir_in = 8'($urandom);
    check("busy_start", 32'(busy), 32'd1);

    foreach (ord[i]) begin
      m        = ord[i];
      cnt      = 0;
      answered = 1'b0;
      ord_s    = {ord_s, $sformatf("%0d", m)};
      while (1) begin
        check("chk_valid", 32'(chk_valid), 32'd1);
        check("chk_id", 32'(chk_id), 32'(m));
        check("chk_dir", 32'(chk_dir), 32'(d[2*m +: 2]));
        if (cnt == 0) check("step_idle", 32'(step), 32'd0);
        if (inject && i == 0 && cnt == 0) begin
          tick  = 1'b1;
          ovr_m = 1'b1;
        end
        if (dl[m] < TO && cnt == dl[m]) begin
          chk_ready = 1'b1;
          chk_free  = fr[m];
          answered  = 1'b1;
        end else begin
          chk_ready = 1'b0;
          chk_free  = 1'($urandom);
        end
        tick_cycle();
        tick = 1'b0;
        cnt++;
        if (answered || cnt == TO) break;
      end
      if (!answered) tmo_m = 1'b1;
      // Strobes with no query outstanding must be ignored.
      chk_ready = 1'($urandom);
      chk_free  = 1'($urandom);
      exp_step = (answered && fr[m]) ? 4'(4'b0001 << m) : 4'b0000;
      check("commit_valid", 32'(chk_valid), 32'd0);
      check("step", 32'(step), 32'(exp_step));
      if (exp_step != 4'd0) check("step_dir", 32'(step_dir), 32'(d[2*m +: 2]));
      check("timeout_err", 32'(timeout_err), 32'(tmo_m));
      tick_cycle();
    end

    // Empty ISSUE cycle
    check("last_valid", 32'(chk_valid), 32'd0);
    check("last_step", 32'(step), 32'd0);
    check("early_done", 32'(round_done), 32'd0);
    tick_cycle();
    // DONE
    check("round_done", 32'(round_done), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    ptr_m = (ptr_m + 1) % 4;
    tick_cycle();
    // Back in IDLE
    check("done_pulse", 32'(round_done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("overrun", 32'(overrun), 32'(ovr_m));
    check("timeout_sticky", 32'(timeout_err), 32'(tmo_m));
    chk_ready = 1'b0;
    $display("round %0d req=%b dir=%h free=%b order=%s inject=%0d", round_no, r, d, fr, ord_s, inject);
    round_no++;
  endtask

  int dl [4];

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(chk_valid), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'({overrun, timeout_err, round_done}), 32'd0);
    rst = 1'b1;
    tick_cycle();

    // All four movers free, immediate answers.
    dl = '{0, 0, 0, 0};
    run_round(4'b1111, 8'b11100100, 4'b1111, dl, 1'b0);
    // Second round starts from ptr=1.
    run_round(4'b1111, 8'b11100100, 4'b1111, dl, 1'b0);
    // Mover 2 blocked by a wall.
    run_round(4'b0101, 8'h5A, 4'b1011, dl, 1'b0);
    // Mover 1 never answered.
    dl = '{0, 20, 0, 0};
    run_round(4'b0010, 8'hC3, 4'b1111, dl, 1'b0);
    // Empty round.
    dl = '{0, 0, 0, 0};
    run_round(4'b0000, 8'h00, 4'b0000, dl, 1'b0);
    // Stray tick mid-round.
    dl = '{1, 2, 0, 3};
    run_round(4'b1111, 8'h1B, 4'b0110, dl, 1'b1);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++) begin
        dl[k] = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      end
      run_round(4'($urandom), 8'($urandom), 4'($urandom), dl, ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a stalled query.
    tick   = 1'b1;
    req    = 4'b1111;
    dir_in = 8'hFF;
    chk_ready = 1'b0;
    tick_cycle();
    tick = 1'b0;
    repeat (5) tick_cycle();
    check("pre_rst_valid", 32'(chk_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(chk_valid), 32'd0);
    check("arst_id_dir", 32'({chk_id, chk_dir}), 32'd0);
    check("arst_step", 32'({step, step_dir}), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_flags", 32'({overrun, timeout_err, round_done}), 32'd0);
    $display("reset mid-wait applied");
    repeat (2) @(posedge clk);
    #2;
    rst   = 1'b1;
    ptr_m = 0;
    ovr_m = 1'b0;
    tmo_m = 1'b0;
    tick_cycle();
    dl = '{0, 1, 0, 2};
    run_round(4'b1111, 8'b11100100, 4'b1101, dl, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
